// File: rtl/fc_pkg.sv
// Shared definitions for the fc_vector_writer slice: default widths, Q2.14 rails,
// controller states and the accumulator-to-Q2.14 saturation (ReLU variant under FC_WRITER_RELU_EN).
package fc_pkg;

    localparam int FC_ADDR_W     = 12;
    localparam int FC_DATA_W     = 16;
    localparam int FC_ACC_W      = 32;
    localparam int FC_FRAC_SHIFT = 14;
    localparam int FC_FIFO_DEPTH = 4;

    localparam logic [FC_DATA_W-1:0] Q2_14_MAX = 16'h7FFF;
    localparam logic [FC_DATA_W-1:0] Q2_14_MIN = 16'h8000;

    // Q2.14 rails sign-extended to accumulator width, for comparing after the shift
    localparam logic signed [FC_ACC_W-1:0] ACC_Q_MAX = 32767;
    localparam logic signed [FC_ACC_W-1:0] ACC_Q_MIN = -32768;

    localparam logic [7:0] SAT_COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [FC_DATA_W-1:0] data;
        logic                 clamped;
    } sat_t;

    function automatic sat_t saturate(input logic signed [FC_ACC_W-1:0] acc, input int shift);
        logic signed [FC_ACC_W-1:0] s;
        sat_t r;
        s = acc;
`ifdef FC_WRITER_RELU_EN
        if (s < 0) s = '0;
`endif
        s = s >>> shift;
        r.data    = s[FC_DATA_W-1:0];
        r.clamped = 1'b0;
        if (s > ACC_Q_MAX) begin
            r.data    = Q2_14_MAX;
            r.clamped = 1'b1;
        end else if (s < ACC_Q_MIN) begin
            r.data    = Q2_14_MIN;
            r.clamped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_wr_fifo.sv
// Small synchronous FIFO between the producer stream and the SRAM write port.
// Combinational read of the head entry; full/empty derived from wrap-bit pointers.
module fc_wr_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/fc_vector_writer.sv
// Streams signed accumulators into the activation SRAM as saturated Q2.14 words.
// Define FC_WRITER_RELU_EN to clamp negative inputs to zero before rescaling.
module fc_vector_writer
    import fc_pkg::*;
#(
    parameter int ADDR_W     = FC_ADDR_W,
    parameter int DATA_W     = FC_DATA_W,
    parameter int ACC_W      = FC_ACC_W,
    parameter int FRAC_SHIFT = FC_FRAC_SHIFT,
    parameter int FIFO_DEPTH = FC_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_start_address,
    input  logic [ADDR_W-1:0] length,
    input  logic              in_valid,
    input  logic [ACC_W-1:0]  in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              busy,
    output logic              done,
    output logic [7:0]        sat_count
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] accepted;
    logic [ADDR_W-1:0] written;

    sat_t              conv;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;

    // in_ready depends only on registered state, never on this cycle's pop
    assign in_ready = (state == ST_RUN) && !fifo_full && (accepted < len);
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_RUN) && !fifo_empty;
    assign conv     = saturate(in_data, FRAC_SHIFT);

    fc_wr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (conv.data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: default assigned first so no path through this block can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = (length == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (pop && (written + 1'b1) == len) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            addr         <= '0;
            len          <= '0;
            accepted     <= '0;
            written      <= '0;
            sram_address <= '0;
            sram_wdata   <= '0;
            sram_we      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sat_count    <= '0;
        end else begin
            state   <= state_next;
            sram_we <= pop;
            // done and busy change together one cycle after the DONE state is entered
            done    <= (state == ST_DONE);
            if (state == ST_DONE) busy <= 1'b0;

            if (state == ST_IDLE && start) begin
                addr      <= dest_start_address;
                len       <= length;
                accepted  <= '0;
                written   <= '0;
                sat_count <= '0;
                busy      <= 1'b1;
            end

            if (push) begin
                accepted <= accepted + 1'b1;
                if (conv.clamped && sat_count != SAT_COUNT_MAX) sat_count <= sat_count + 8'd1;
            end

            if (pop) begin
                sram_wdata   <= fifo_data;
                sram_address <= addr;
                addr         <= addr + 1'b1;
                written      <= written + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fc_vector_writer.sv
// Scoreboard bench for fc_vector_writer: the driver queues expected SRAM writes from an
// arithmetic reference model, a negedge monitor pops and compares every write strobe.
module tb_fc_vector_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] dest_start_address;
    logic [11:0] length;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [11:0] sram_address;
    logic [15:0] sram_wdata;
    logic        sram_we;
    logic        busy;
    logic        done;
    logic [7:0]  sat_count;

    fc_vector_writer dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .dest_start_address (dest_start_address),
        .length             (length),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .sram_address       (sram_address),
        .sram_wdata         (sram_wdata),
        .sram_we            (sram_we),
        .busy               (busy),
        .done               (done),
        .sat_count          (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] data_q[$];

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int last_wr_cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    logic we_at_done = 1'b0;

    logic [11:0] cur_dest;
    int          exp_idx;
    int          exp_sat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference conversion: floor(v / 2^14), optional ReLU, clamp to the Q2.14 range
    task automatic ref_conv(input logic [31:0] raw, output logic [15:0] d, output bit c);
        longint x;
        longint q;
        x = longint'($signed(raw));
`ifdef FC_WRITER_RELU_EN
        if (x < 0) x = 0;
`endif
        if (x >= 0) q = x / 16384;
        else        q = -((-x + 16383) / 16384);
        c = 1'b0;
        if (q > 32767)       begin q = 32767;  c = 1'b1; end
        else if (q < -32768) begin q = -32768; c = 1'b1; end
        d = 16'(q);
    endtask

    task automatic push_exp(input logic [31:0] v, input int acc_cyc);
        exp_t e;
        bit   c;
        ref_conv(v, e.data, c);
        e.addr = 12'(cur_dest + exp_idx);
        e.cyc  = acc_cyc + 2;
        exp_q.push_back(e);
        exp_idx++;
        if (c && exp_sat < 255) exp_sat++;
    endtask

    // Monitor: every write strobe must match the head of the scoreboard, including its cycle
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            we_at_done = sram_we;
        end
        if (sram_we) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL spurious_write: addr 0x%0h data 0x%0h with nothing expected", sram_address, sram_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(sram_address), 32'(mon_e.addr));
                check("write_data", 32'(sram_wdata), 32'(mon_e.data));
                check("write_cycle", cyc, mon_e.cyc);
            end
        end
    end

    function automatic logic [31:0] rand_acc();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 32'h3FFF_FFFF)) - 32'h2000_0000;
            2:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return (32'd32767 * 32'd16384 + 32'($urandom_range(0, 1)) * 32'd16384)
                            ^ (($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0);
        endcase
    endfunction

    // Called at posedge+1. mode: 0 = valid held high, 1 = toggled, 2 = random.
    task automatic do_xfer(input logic [11:0] dest, input logic [11:0] len, input int mode, input bit busy_start);
        int start_cyc;
        int d0;
        int w0;
        int budget;
        int i;
        int exp_done;
        d0 = done_cnt;
        w0 = wr_cnt;
        cur_dest = dest;
        exp_idx = 0;
        exp_sat = 0;
        start = 1'b1;
        dest_start_address = dest;
        length = len;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);

        i = 0;
        budget = 0;
        while (i < data_q.size() && budget < 4 * int'(len) + 50) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (budget % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = data_q[i];
            if (busy_start && budget == 3) begin
                start = 1'b1;
                dest_start_address = dest ^ 12'h0F0;
                length = len + 12'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                push_exp(in_data, cyc);
                i++;
            end
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        check("all_words_accepted", i, data_q.size());

        in_valid = 1'b1;
        in_data = $urandom;
        repeat (2) begin
            @(negedge clk);
            check("in_ready_beyond_length", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        budget = 0;
        while (done_cnt == d0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        exp_done = (len == 0) ? start_cyc + 2 : last_wr_cyc + 1;
        check("done_pulses", done_cnt - d0, 1);
        check("done_cycle", last_done_cyc, exp_done);
        check("we_low_at_done", 32'(we_at_done), 0);
        check("write_count", wr_cnt - w0, int'(len));
        check("scoreboard_drained", exp_q.size(), 0);
        check("sat_count", 32'(sat_count), exp_sat);
        check("busy_idle", 32'(busy), 0);
        check("done_idle", 32'(done), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values();
        check("rst_sram_address", 32'(sram_address), 0);
        check("rst_sram_wdata", 32'(sram_wdata), 0);
        check("rst_sram_we", 32'(sram_we), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sat_count", 32'(sat_count), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        int budget;
        reset = 1'b1;
        start = 1'b0;
        dest_start_address = '0;
        length = '0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        data_q = '{32'h0000_4000, 32'h0000_8000, 32'hFFFF_C000};
        do_xfer(12'h100, 12'd3, 0, 1'b0);

        data_q = '{32'h7FFF_FFFF, 32'h8000_0000};
        do_xfer(12'h040, 12'd2, 0, 1'b0);

        data_q = '{rand_acc(), rand_acc(), rand_acc(), rand_acc()};
        do_xfer(12'hFFE, 12'd4, 0, 1'b0);

        data_q.delete();
        do_xfer(12'h123, 12'd0, 0, 1'b0);

        data_q = '{rand_acc(), rand_acc(), rand_acc(), rand_acc(), rand_acc()};
        do_xfer(12'h380, 12'd5, 1, 1'b1);

        data_q.delete();
        for (int k = 0; k < 300; k++) data_q.push_back(32'h7FFF_FFFF);
        do_xfer(12'h500, 12'd300, 0, 1'b0);

        // Reset in the middle of a 5-word transfer
        cur_dest = 12'h200;
        exp_idx = 0;
        exp_sat = 0;
        w0 = wr_cnt;
        d0 = done_cnt;
        start = 1'b1;
        dest_start_address = 12'h200;
        length = 12'd5;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        budget = 0;
        while (wr_cnt - w0 < 2 && budget < 20) begin
            in_data = rand_acc();
            @(negedge clk);
            if (in_valid && in_ready) push_exp(in_data, cyc);
            @(posedge clk); #1;
            budget++;
        end
        check("reset_test_progress", 32'(wr_cnt - w0 >= 2), 1);
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("no_done_after_reset", done_cnt - d0, 0);
        @(posedge clk); #1;

        data_q = '{rand_acc(), rand_acc(), rand_acc()};
        do_xfer(12'h300, 12'd3, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(0, 12);
            data_q.delete();
            for (int k = 0; k < n; k++) data_q.push_back(rand_acc());
            do_xfer(12'($urandom), 12'(n), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fc_vector_writer.md
# fc_vector_writer

Streaming write-back engine that takes signed accumulator results from a compute layer, rescales and saturates them to 16-bit fixed point, and writes them sequentially into the activation SRAM. It is the producing end of the SRAM vector interface: it fills the vector region that the fully connected classifier later reads word by word from its source start address. A small input FIFO decouples the producer's valid/ready stream from the one-write-per-cycle SRAM port.

## Interface
- ADDR_W, 12, SRAM address width
- DATA_W, 16, stored word width (Q2.14)
- ACC_W, 32, signed input accumulator width
- FRAC_SHIFT, 14, arithmetic right shift applied before saturation
- FIFO_DEPTH, 4, input buffer entries, power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin a transfer; sampled only in IDLE
- dest_start_address  in  ADDR_W  first SRAM word written
- length  in  ADDR_W  number of words to write; 0 allowed
- in_valid  in  1  in_data valid
- in_data  in  ACC_W  signed accumulator value
- in_ready  out  1  word accepted on edge where in_valid & in_ready
- sram_address  out  ADDR_W  write address
- sram_wdata  out  DATA_W  write data
- sram_we  out  1  write strobe, one word per cycle
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at completion
- sat_count  out  8  number of saturated words this transfer, sticks at 255

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches dest_start_address, length; clears sat_count, accepted and written counters; busy←1; to RUN, or to DONE if length==0.
- RUN: in_ready = FIFO not full AND accepted < length; computed from registered state only (no combinational path from pop).
- Conversion at FIFO input: s = in_data >>> FRAC_SHIFT; s > 32767 → 32767, s < −32768 → −32768, each clamp increments sat_count.
- Each cycle FIFO non-empty: pop one entry, register sram_we=1, sram_wdata=entry, sram_address=current address; address += 1 modulo 2^ADDR_W (wraps 0xFFF→0x000 silently).
- When written == length: to DONE. DONE: done=1, busy=0 for one cycle, then IDLE.
- start while busy: ignored. in_valid while in_ready=0 or in IDLE: data ignored, not buffered.
- Words beyond length never accepted (in_ready held low).

## Timing
- Reset values: sram_address 0, sram_wdata 0, sram_we 0, in_ready 0, busy 0, done 0, sat_count 0; FIFO emptied, state IDLE.
- Reset mid-transfer: aborts immediately, no further writes, no done pulse.
- Latency: word accepted at edge k → sram_we=1 with its data in the cycle after edge k+1.
- Throughput: one word per cycle sustained when in_valid held high.
- sram_we deasserts the cycle after the last write; done pulses the cycle after the last write; busy falls with done.
- length==0: done pulses on the second cycle after start, sram_we never asserted.
- Full FIFO with simultaneous pop: in_ready still low that cycle; rises next cycle.

## Configuration
- FC_WRITER_RELU_EN defined: negative in_data clamped to 0 before shift; only positive overflow saturates/counts.
- Undefined: signed saturation on both rails as above.

## Structure
- Shared package fc_pkg: ADDR_W/DATA_W/ACC_W defaults, Q2.14 min/max constants, state enum, saturation function.
- One sub-module: fc_wr_fifo (synchronous FIFO, DATA_W wide, FIFO_DEPTH entries, full/empty flags).

## Test plan
- dest=0x100, length=3, in_data 0x4000, 0x8000, −0x4000 back-to-back → writes 0x100:0x0001, 0x101:0x0002, 0x102:0xFFFF; done one pulse; sat_count 0.
- length=2, in_data 0x7FFF_FFFF then 0x8000_0000 → wdata 0x7FFF, 0x8000, sat_count 2 (RELU_EN: 0x7FFF, 0x0000, sat_count 1).
- dest=0xFFE, length=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- length=0 → no sram_we, done after 2 cycles; start pulsed during busy → no second transfer.
- Stall producer: in_valid toggled every other cycle, length=5 → exactly 5 writes, in order, in_ready low after 5th acceptance.
- Reset asserted after 2 of 5 writes → sram_we 0 next cycle, no done, next start writes from new dest cleanly.
